// File: rtl/event_frag_packer.sv
// Purpose: splits a 64-bit event stream into fragments of at most FRAG_QWORDS data qwords, each framed by a header and a trailer qword.
// Latency: data qwords pass through combinationally; each fragment costs 2 extra cycles (header, trailer); tx strobes lag the handshake by 1 cycle.
// Backpressure: m_axis_tready feeds straight back to s_axis_tready during DATA; s_axis_tready is low in every other state; valid is held until accepted.
//
// Ports:
//   aclk, rst_i                  clock, synchronous active-high reset
//   enable_i                     permits the start of a new event (looked at only while idle)
//   s_axis_tdata/tvalid/tready/tlast   upstream event qwords, tlast marks the final qword of an event
//   m_axis_tdata/tvalid/tready/tlast   framed output, tlast marks each trailer qword
//   tx_qword_o                   1-cycle pulse per accepted output qword
//   tx_event_o                   1-cycle pulse per accepted final trailer of an event
module event_frag_packer #(
    parameter int unsigned FRAG_QWORDS = 1024
) (
    input  logic        aclk,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        tx_qword_o,
    output logic        tx_event_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_DATA    = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] frag_idx;
        logic [31:0] evnum;
    } hdr_t;

    typedef struct packed {
        logic [15:0] sync;
        logic        last;
        logic [30:0] rsvd;
        logic [15:0] cnt;
    } trl_t;

    localparam logic [15:0] FRAG_MAX = 16'(FRAG_QWORDS);

    state_t      state_q, state_d;
    logic [31:0] evnum_q, evnum_d;
    logic [15:0] frag_idx_q, frag_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_flag_q, last_flag_d;
    logic        tx_qword_q, tx_qword_d;
    logic        tx_event_q, tx_event_d;

    hdr_t        hdr;
    trl_t        trl;
    logic        out_acc;
    logic [15:0] cnt_inc;
    logic        frag_end;

    assign out_acc  = m_axis_tvalid & m_axis_tready;
    assign cnt_inc  = cnt_q + 16'd1;
    // A fragment closes on the event's final qword or when it reaches the size limit;
    // both at once yields a single closing trailer with last set, never an empty fragment.
    assign frag_end = s_axis_tlast | (cnt_inc == FRAG_MAX);

    // State and counter registers
    always_ff @(posedge aclk) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            evnum_q     <= '0;
            frag_idx_q  <= '0;
            cnt_q       <= '0;
            last_flag_q <= 1'b0;
            tx_qword_q  <= 1'b0;
            tx_event_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            evnum_q     <= evnum_d;
            frag_idx_q  <= frag_idx_d;
            cnt_q       <= cnt_d;
            last_flag_q <= last_flag_d;
            tx_qword_q  <= tx_qword_d;
            tx_event_q  <= tx_event_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d     = state_q;
        evnum_d     = evnum_q;
        frag_idx_d  = frag_idx_q;
        cnt_d       = cnt_q;
        last_flag_d = last_flag_q;
        tx_qword_d  = out_acc;
        tx_event_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && enable_i) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (m_axis_tready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (s_axis_tvalid && m_axis_tready) begin
                    cnt_d = cnt_inc;
                    if (frag_end) begin
                        last_flag_d = s_axis_tlast;
                        state_d     = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER: begin
                if (m_axis_tready) begin
                    cnt_d = '0;
                    if (last_flag_q) begin
                        evnum_d    = evnum_q + 32'd1;
                        frag_idx_d = '0;
                        tx_event_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Continuation fragment: straight to the next header, enable_i not consulted.
                        frag_idx_d = frag_idx_q + 16'd1;
                        state_d    = ST_HEADER;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        hdr           = '{sync: 16'hEB90, frag_idx: frag_idx_q, evnum: evnum_q};
        trl           = '{sync: 16'hEBF0, last: last_flag_q, rsvd: 31'd0, cnt: cnt_q};
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        case (state_q)
            ST_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr;
            end
            ST_DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
            end
            ST_TRAILER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = trl;
            end
            default: ;
        endcase
    end

    assign tx_qword_o = tx_qword_q;
    assign tx_event_o = tx_event_q;

endmodule

// File: tb/tb_event_frag_packer.sv
// Purpose: directed self-checking bench for event_frag_packer with FRAG_QWORDS=4.
// Latency: expectations assume pass-through data, 2 framing qwords per fragment, strobes 1 cycle late.
// Backpressure: optional random m_axis_tready and s_axis_tvalid throttling.
module tb_event_frag_packer;

    logic        aclk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        tx_qword_o;
    logic        tx_event_o;

    event_frag_packer #(.FRAG_QWORDS(4)) dut (
        .aclk(aclk), .rst_i(rst_i), .enable_i(enable_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .tx_qword_o(tx_qword_o), .tx_event_o(tx_event_o)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];
    int          qw_cnt = 0;
    int          ev_cnt = 0;
    int          strobe_err = 0;
    int          stall_err = 0;
    bit          mon_on = 0;
    bit          throttle = 0;
    logic [31:0] exp_ev = 0;

    // Monitor: records accepted beats, counts strobes, checks strobe timing and stall stability.
    bit          p_acc = 0, p_evt = 0, p_rst = 0, p_stall = 0;
    logic [63:0] p_dat = '0;
    always @(negedge aclk) begin
        if (mon_on) begin
            if (tx_qword_o !== (p_acc && !p_rst)) strobe_err++;
            if (tx_event_o !== (p_evt && !p_rst)) strobe_err++;
            if (tx_qword_o === 1'b1) qw_cnt++;
            if (tx_event_o === 1'b1) ev_cnt++;
            if (p_stall && !p_rst && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_dat)) stall_err++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
                got_q.push_back({m_axis_tlast, m_axis_tdata});
        end
        p_acc   = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1);
        p_evt   = p_acc && (m_axis_tlast === 1'b1) && (m_axis_tdata[47] === 1'b1);
        p_rst   = (rst_i === 1'b1);
        p_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        p_dat   = m_axis_tdata;
    end

    always begin
        @(posedge aclk);
        #1;
        if (throttle) m_axis_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    task automatic clr();
        got_q.delete();
        qw_cnt    = 0;
        ev_cnt    = 0;
        stall_err = 0;
    endtask

    task automatic build_exp(input int n, input logic [63:0] base, input logic [31:0] ev);
        int i;
        int c;
        logic [15:0] frag;
        exp_q.delete();
        i    = 0;
        frag = 0;
        while (i < n) begin
            exp_q.push_back({1'b0, 16'hEB90, frag, ev});
            c = 0;
            while (c < 4 && i < n) begin
                exp_q.push_back({1'b0, base + 64'(i)});
                c++;
                i++;
            end
            exp_q.push_back({1'b1, 16'hEBF0, (i == n), 31'd0, 16'(c)});
            frag++;
        end
    endtask

    task automatic send_event(input int n, input logic [63:0] base, input bit thr,
                              input bit tlast_en, input int drop_at);
        for (int i = 0; i < n; i++) begin
            bit hs;
            hs = 0;
            if (thr) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            if (i == drop_at) enable_i = 1'b0;
            s_axis_tdata  = base + 64'(i);
            s_axis_tlast  = tlast_en && (i == n - 1);
            s_axis_tvalid = 1'b1;
            for (int k = 0; k < 200 && !hs; k++) begin
                @(negedge aclk);
                hs = (s_axis_tready === 1'b1);
                @(posedge aclk);
                #1;
            end
            if (!hs) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout beat %0d: no handshake, required within 200 cycles", i);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        for (int k = 0; k < 300 && got_q.size() < n; k++) begin @(posedge aclk); #1; end
        repeat (3) begin @(posedge aclk); #1; end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 mon_on = 1;
        @(negedge aclk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rst_s_tready: got %b expected 0", s_axis_tready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_m_tlast: got %b expected 0", m_axis_tlast); end
        n_cmp++; if (tx_qword_o !== 1'b0) begin n_bad++; $display("FAIL rst_tx_qword: got %b expected 0", tx_qword_o); end
        n_cmp++; if (tx_event_o !== 1'b0) begin n_bad++; $display("FAIL rst_tx_event: got %b expected 0", tx_event_o); end
        @(posedge aclk); #1;
        rst_i = 1'b0;
        @(posedge aclk); #1;
    endtask

    // Shared body for the plain event scenarios: n data qwords, optional throttling.
    task automatic test_event(input string nm, input int n, input logic [63:0] base, input bit thr);
        logic [64:0] g;
        clr();
        build_exp(n, base, exp_ev);
        if (thr) throttle = 1;
        send_event(n, base, thr, 1'b1, -1);
        wait_outputs(exp_q.size());
        throttle = 0;
        m_axis_tready = 1'b1;
        wait_outputs(exp_q.size());
        exp_ev++;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL %s_nbeats: got %0d expected %0d", nm, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_cmp++;
            if (g !== exp_q[i]) begin n_bad++; $display("FAIL %s_beat%0d: got %h expected %h", nm, i, g, exp_q[i]); end
        end
        n_cmp++; if (qw_cnt != exp_q.size()) begin n_bad++; $display("FAIL %s_qword_pulses: got %0d expected %0d", nm, qw_cnt, exp_q.size()); end
        n_cmp++; if (ev_cnt != 1) begin n_bad++; $display("FAIL %s_event_pulses: got %0d expected 1", nm, ev_cnt); end
        n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL %s_stall_hold: got %0d violations expected 0", nm, stall_err); end
        n_cmp++; if (strobe_err != 0) begin n_bad++; $display("FAIL %s_strobe_timing: got %0d errors expected 0", nm, strobe_err); end
    endtask

    task automatic test_basic();
        test_event("t1", 3, 64'hD000_0000_0000_0000, 1'b0);
    endtask

    task automatic test_multi_frag();
        test_event("t2", 9, 64'hD100_0000_0000_0000, 1'b0);
    endtask

    task automatic test_exact_frag();
        test_event("t3", 4, 64'hD200_0000_0000_0000, 1'b0);
        @(negedge aclk);
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL t3_idle_tvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (got_q.size() != 6) begin n_bad++; $display("FAIL t3_no_extra_header: got %0d beats expected 6", got_q.size()); end
        @(posedge aclk); #1;
    endtask

    task automatic test_back_to_back_throttled();
        test_event("t4", 9, 64'hD100_0000_0000_0000, 1'b1);
    endtask

    task automatic test_enable();
        logic [64:0] g;
        clr();
        enable_i = 1'b0;
        s_axis_tdata = 64'hD300_0000_0000_0000;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            n_cmp++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                n_bad++; $display("FAIL t5_disabled_c%0d: got tready=%b tvalid=%b expected 0 0", c, s_axis_tready, m_axis_tvalid);
            end
            @(posedge aclk); #1;
        end
        enable_i = 1'b1;
        build_exp(6, 64'hD300_0000_0000_0000, exp_ev);
        send_event(6, 64'hD300_0000_0000_0000, 1'b0, 1'b1, 2);
        wait_outputs(exp_q.size());
        enable_i = 1'b1;
        exp_ev++;
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL t5_nbeats: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_cmp++;
            if (g !== exp_q[i]) begin n_bad++; $display("FAIL t5_beat%0d: got %h expected %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (ev_cnt != 1) begin n_bad++; $display("FAIL t5_event_pulses: got %0d expected 1", ev_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [64:0] g;
        clr();
        build_exp(9, 64'hD400_0000_0000_0000, exp_ev);
        // First fragment plus one qword of the second, then reset while upstream still offers data.
        send_event(5, 64'hD400_0000_0000_0000, 1'b0, 1'b0, -1);
        s_axis_tdata = 64'hD400_0000_0000_0005;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        rst_i = 1'b1;
        @(posedge aclk); #1;
        rst_i = 1'b0;
        enable_i = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL t6_after_rst_tvalid: got %b expected 0", m_axis_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_bad++; $display("FAIL t6_after_rst_tready: got %b expected 0", s_axis_tready); end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        enable_i = 1'b1;
        repeat (4) begin @(posedge aclk); #1; end
        n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL t6_nbeats: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_cmp++;
            if (g !== exp_q[i]) begin n_bad++; $display("FAIL t6_beat%0d: got %h expected %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (ev_cnt != 0) begin n_bad++; $display("FAIL t6_no_event_pulse: got %0d expected 0", ev_cnt); end
        n_cmp++; if (qw_cnt != 8) begin n_bad++; $display("FAIL t6_qword_pulses: got %0d expected 8", qw_cnt); end
        exp_ev = 0;
        test_event("t6_next", 3, 64'hD500_0000_0000_0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_frag();
        test_exact_frag();
        test_back_to_back_throttled();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
